fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of decode and driven by the hazard unit's PC_en / F_D_en / PCSrc / Flush outputs. Holds the PC and issues the instruction-memory address. Registers the fetched instruction into the F/D pipeline register. Optionally predicts taken branches with a direct-mapped BTB of 2-bit saturating counters.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BTB_ENTRIES, 16, number of BTB entries; power of two, 4..256.
XLEN, 32, address/data width.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
pc_en  in  1  PC update enable (0 = stall PC)
fd_en  in  1  F/D register enable (0 = hold)
pcsrc  in  1  redirect PC to redirect_target
flush  in  1  invalidate F/D contents (load NOP)
redirect_target  in  XLEN  resolved target from execute
imem_addr  out  XLEN  instruction memory address (= current PC)
imem_rdata  in  32  instruction word, combinational read of imem_addr
d_instr  out  32  F/D instruction
d_pc  out  XLEN  F/D PC
d_pc_plus4  out  XLEN  F/D PC+4
d_pred_taken  out  1  fetch predicted taken (0 when feature off)
d_valid  out  1  F/D holds a real instruction
upd_valid  in  1  execute resolved a branch/jump this cycle
upd_taken  in  1  resolved outcome
upd_pc  in  XLEN  PC of the resolved instruction
upd_target  in  XLEN  resolved target

Behaviour:
- Reset, rst high at the clock edge:
  - pc=RESET_PC; d_instr=32'h0000_0013 (NOP); d_pc=0; d_pc_plus4=0; d_pred_taken=0; d_valid=0.
  - All BTB valid bits cleared. All counters set to 2'b01 (weakly not-taken).
  - rst mid-operation discards any pending redirect or update.
- imem_addr = pc, combinational. No extra fetch latency: the instruction fetched at PC p appears on d_* one cycle after p is presented.
- Next-PC priority, highest first:
  1. rst
  2. pcsrc: pc <= {redirect_target[XLEN-1:2],2'b00}. Applies even when pc_en=0.
  3. !pc_en: hold pc.
  4. prediction hit: pc <= BTB target.
  5. otherwise pc <= pc+4, wrapping modulo 2^XLEN.
- F/D register:
  - If flush (or rst): load NOP, d_valid=0, d_pred_taken=0. Flush dominates fd_en=0.
  - Else if fd_en: load imem_rdata, pc, pc+4, pred_taken; d_valid=1.
  - Else hold all fields.
- Stall: pc_en=fd_en=0 for N cycles keeps pc and d_* unchanged for N cycles. Release refetches the same PC with no instruction lost.
- BTB (feature on):
  - index = pc[IDX+1:2], IDX=log2(BTB_ENTRIES); tag = pc[XLEN-1:IDX+2].
  - Hit = valid && tag match. Predict taken = hit && counter[1].
  - Update on upd_valid using upd_pc's index: write tag and target, set valid.
  - Counter saturating: +1 if upd_taken, -1 otherwise; stops at 2'b11 and 2'b00.
  - Replaced entry (tag mismatch): counter initialised to 2'b10 if taken, 2'b01 if not.
  - Lookup and update on the same index in the same cycle: lookup sees pre-update state; the update takes effect next cycle.
  - Update is ignored when rst is high.
- Misprediction detection and the pcsrc/flush request are produced downstream. This block only obeys them.

Optional Feature:
BRANCH_PREDICT_EN:
- Defined: BTB instantiated; prediction behaves as described above.
- Undefined: no BTB storage; the upd_* inputs are ignored; d_pred_taken is tied 0; next PC is always pc+4 unless redirected. This matches static predict-not-taken.

Decomposition:
Shared package riscv_pkg holds:
- NOP_INSTR = 32'h0000_0013
- opcode constants (OP_LOAD, OP_BRANCH, OP_JAL, OP_JALR, ...)
- typedef bht_ctr_t (logic [1:0]) with enum STRONG_NT/WEAK_NT/WEAK_T/STRONG_T
Sub-module: branch_target_buffer, containing the lookup and update ports plus the counter arrays. It is instantiated under BRANCH_PREDICT_EN.

Test Plan:
- Reset then run 4 cycles, imem returns 0x00A00093 at every address -> d_pc = 0, 4, 8 on consecutive cycles; d_valid=0 in the first cycle after reset, 1 afterwards.
- At pc=0x10, pc_en=fd_en=0 for 3 cycles, then release -> pc held at 0x10 and d_pc held at 0x0C during the stall; the next d_pc is 0x10.
- pcsrc=1 and flush=1 with redirect_target=0x0000_0103 while pc_en=0 -> next pc=0x100; d_instr=0x00000013, d_valid=0; the following d_pc=0x100.
- Feature on: two taken updates with upd_pc=0x20, target 0x80, then fetch 0x20 -> next pc=0x80 and d_pred_taken=1. Then three not-taken updates -> a later fetch of 0x20 goes to 0x24.
- Feature on: lookup of 0x40 in the same cycle as the first taken update for 0x40 -> this fetch predicts not-taken (next pc 0x44); the next fetch of 0x40 predicts taken.
- pc=0xFFFF_FFFC, no redirect, no hit -> next pc=0x0000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the pipeline front end.
//   NOP_INSTR      : canonical NOP (addi x0, x0, 0) loaded on flush/reset
//   OP_*           : base opcode constants
//   bht_ctr_t      : 2-bit saturating branch-history counter
//   ctr_next()     : saturating counter step toward the resolved outcome
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;
  localparam logic [6:0] OP_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OP_OP     = 7'b011_0011;
  localparam logic [6:0] OP_LUI    = 7'b011_0111;
  localparam logic [6:0] OP_AUIPC  = 7'b001_0111;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bht_ctr_t;

  function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
    bht_ctr_t r;
    r = c;
    if (taken) begin
      if (c != STRONG_T) r = bht_ctr_t'(c + 2'd1);
    end else begin
      if (c != STRONG_NT) r = bht_ctr_t'(c - 2'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating counters.
//   clk, rst         : clock, synchronous active-high reset
//   lookup_pc        : fetch PC, looked up combinationally
//   pred_taken       : entry hit and counter in a taken state
//   pred_target      : stored target for lookup_pc's entry
//   upd_valid/taken  : resolved branch outcome from execute
//   upd_pc/target    : resolved branch PC and target
// Lookup reads the registered arrays, so a same-cycle update to the same
// entry is only visible to the following lookup.
module branch_target_buffer
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic     [ENTRIES-1:0]           valid_q;
  logic     [ENTRIES-1:0][TAGW-1:0] tag_q;
  logic     [ENTRIES-1:0][XLEN-1:0] tgt_q;
  bht_ctr_t [ENTRIES-1:0]           ctr_q;

  logic [IDX-1:0]  li, ui;
  logic [TAGW-1:0] lt, ut;
  logic            lhit, uhit;

  assign li = lookup_pc[IDX+1:2];
  assign lt = lookup_pc[XLEN-1:IDX+2];
  assign ui = upd_pc[IDX+1:2];
  assign ut = upd_pc[XLEN-1:IDX+2];

  assign lhit        = valid_q[li] && (tag_q[li] == lt);
  assign uhit        = valid_q[ui] && (tag_q[ui] == ut);
  assign pred_taken  = lhit && (ctr_q[li] inside {WEAK_T, STRONG_T});
  assign pred_target = tgt_q[li];

  // Word-aligned PCs only: low two bits carry no information here.
  logic unused_lsbs;
  assign unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  // Tag/target storage needs no reset: valid_q gates every use.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WEAK_NT;
    end else if (upd_valid) begin
      valid_q[ui] <= 1'b1;
      tag_q[ui]   <= ut;
      tgt_q[ui]   <= {upd_target[XLEN-1:2], 2'b00};
      // A replaced entry starts weak in the direction just observed.
      ctr_q[ui]   <= uhit ? ctr_next(ctr_q[ui], upd_taken)
                          : (upd_taken ? WEAK_T : WEAK_NT);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC register, imem address, F/D register.
//   clk, rst            : clock, synchronous active-high reset
//   pc_en, fd_en        : hazard-unit stall enables for PC and F/D
//   pcsrc, flush        : redirect to redirect_target / squash F/D
//   imem_addr/rdata     : combinational instruction memory port
//   d_instr, d_pc, d_pc_plus4, d_pred_taken, d_valid : F/D register
//   upd_*               : branch resolution feedback for the BTB
// Optional: define BRANCH_PREDICT_EN to instantiate the BTB; otherwise
// fetch is static predict-not-taken and upd_* are ignored.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  parameter int          XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_en,
  input  logic            fd_en,
  input  logic            pcsrc,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     d_instr,
  output logic [XLEN-1:0] d_pc,
  output logic [XLEN-1:0] d_pc_plus4,
  output logic            d_pred_taken,
  output logic            d_valid,
  input  logic            upd_valid,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target
);

  logic [XLEN-1:0] pc, pc_plus4, pred_target;
  logic            pred_taken;

  assign imem_addr = pc;
  assign pc_plus4  = pc + XLEN'(4);

`ifdef BRANCH_PREDICT_EN
  branch_target_buffer #(
    .XLEN   (XLEN),
    .ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc  (pc),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (upd_valid),
    .upd_taken  (upd_taken),
    .upd_pc     (upd_pc),
    .upd_target (upd_target)
  );
`else
  assign pred_taken  = 1'b0;
  assign pred_target = '0;
  logic unused_upd;
  assign unused_upd = ^{upd_valid, upd_taken, upd_pc, upd_target};
`endif

  // Redirect outranks the stall: a resolved branch must land even while
  // the hazard unit is holding the front end.
  always_ff @(posedge clk) begin
    if (rst)         pc <= XLEN'(RESET_PC);
    else if (pcsrc)  pc <= {redirect_target[XLEN-1:2], 2'b00};
    else if (pc_en)  pc <= pred_taken ? pred_target : pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      d_instr      <= NOP_INSTR;
      d_valid      <= 1'b0;
      d_pred_taken <= 1'b0;
      if (rst) begin
        d_pc       <= '0;
        d_pc_plus4 <= '0;
      end
    end else if (fd_en) begin
      d_instr      <= imem_rdata;
      d_pc         <= pc;
      d_pc_plus4   <= pc_plus4;
      d_pred_taken <= pred_taken;
      d_valid      <= 1'b1;
    end
  end

endmodule
